control_partida: RTL and testbench
==================================

// Module: control_partida
// PURPOSE
//  Game-round controller; the responder side of the main-menu interface.
//  - Consumes the menu's state code, level code and one-cycle load strobe.
//  - Runs one round: lives, countdown timer, frog arrivals at the goal.
//  - Returns the win/lose flags that move the menu from Juego (111) to GanarJuego or PerderJuego.
// PARAMETERS
//  DATAWIDTH_ESTADO  3   width of menu state code
//  DATAWIDTH_NIVEL   2   width of level code
//  DATAWIDTH_TIEMPO  8   width of countdown counter
//  VIDAS_INI         3   lives at round start (1..3)
//  LLEGADAS_META     3   arrivals needed to win (1..7)
//  TIEMPO_BASE       60  ticks per life at level 0
//  TIEMPO_PASO       10  ticks removed per level step; TIEMPO_BASE-3*TIEMPO_PASO must be >=1
// PORTS
//  CP_CLOCK_50    in   1  system clock, 50 MHz, rising edge
//  CP_RESET       in   1  reset: asynchronous, active-low
//  CP_ESTADO_IN   in   3  menu state code (001..100 level select, 111 in game, 000 idle/finish)
//  CP_NVL_IN      in   2  menu level code, valid while CP_CN_IN=1
//  CP_CN_IN       in   1  menu load strobe, one cycle
//  CP_TICK        in   1  one-cycle timebase pulse
//  CP_LLEGADA     in   1  one-cycle pulse: frog reached the goal row
//  CP_CHOQUE      in   1  one-cycle pulse: frog collided or drowned
//  CP_GANO        out  1  round won; held until cleared
//  CP_PERDIO      out  1  round lost; held until cleared
//  CP_RESPAWN     out  1  one-cycle pulse: reposition frog at start
//  CP_ACTIVO      out  1  high while the state is JUGANDO or RESPAWN
//  CP_NVL_OUT     out  2  latched level, drives vehicle speed
//  CP_VIDAS       out  2  remaining lives
//  CP_TIEMPO      out  8  remaining ticks for the current life
//  CP_LLEGADAS    out  3  arrivals this round
// BEHAVIOUR
//  - All outputs are registered or decoded from state; none are combinational from inputs.
//  - Reset (CP_RESET=0, any time, asynchronous): state IDLE; every output 0.
//  - Finish request: CP_CN_IN=1 with CP_ESTADO_IN=000.
//    - From any state, next edge: IDLE, counters cleared, CP_NVL_OUT cleared.
//    - This rule has priority over every other transition.
//  - IDLE:
//    - CP_CN_IN=1 with CP_ESTADO_IN in 001..100 -> ARMADO.
//    - Load: CP_NVL_OUT=CP_NVL_IN, CP_VIDAS=VIDAS_INI, CP_LLEGADAS=0,
//      CP_TIEMPO=TIEMPO_BASE-TIEMPO_PASO*CP_NVL_IN (unsigned, DATAWIDTH_TIEMPO bits).
//    - CP_CN_IN with any other code is ignored.
//  - ARMADO: CP_ESTADO_IN=111 -> JUGANDO next edge. All event inputs are ignored.
//  - JUGANDO: at most one event is acted on per cycle. Priority: CHOQUE > LLEGADA > TICK.
//    - CHOQUE, CP_VIDAS>1: CP_VIDAS-1, CP_TIEMPO reloaded, -> RESPAWN.
//    - CHOQUE, CP_VIDAS==1: CP_VIDAS=0, -> PERDIDO.
//    - LLEGADA, CP_LLEGADAS+1==LLEGADAS_META: CP_LLEGADAS+1, -> GANADO.
//    - LLEGADA otherwise: CP_LLEGADAS+1, CP_TIEMPO reloaded, -> RESPAWN.
//    - TICK with CP_TIEMPO==1: handled exactly as CHOQUE (timeout). CP_TIEMPO never underflows.
//    - TICK otherwise: CP_TIEMPO-1.
//  - RESPAWN: one cycle; CP_RESPAWN=1; events in this cycle are dropped; -> JUGANDO.
//  - GANADO: CP_GANO=1. PERDIDO: CP_PERDIO=1.
//    - Counters frozen; both states hold until a finish request or reset.
//  - Latency: an event in cycle n is reflected in the counters/flags after edge n+1.
//    The menu sees CP_GANO/CP_PERDIO on the edge after that.
//  - CP_GANO and CP_PERDIO are never high together.
// TESTING
//  1. Drive CP_RESET=0 mid-cycle -> all outputs 0 at once, with no clock edge.
//  2. CN=1, ESTADO=011, NVL=10, then ESTADO=111 -> TIEMPO=40, VIDAS=3, NVL_OUT=10;
//     3 LLEGADA pulses -> RESPAWN after 1st and 2nd, LLEGADAS=3, GANO=1.
//  3. Level 0, 3 CHOQUE pulses -> VIDAS 2,1,0; 2 RESPAWN pulses; PERDIO=1, GANO=0.
//  4. Level 3, 30 TICK pulses -> TIEMPO 30..1, then VIDAS=2, TIEMPO=30, RESPAWN=1.
//  5. CHOQUE+LLEGADA+TICK in the same cycle, VIDAS=3, TIEMPO=50 -> VIDAS=2, LLEGADAS=0, TIEMPO=50.
//  6. In GANADO, CN=1 with ESTADO=000 -> IDLE, GANO=0, all counters 0.
//     In JUGANDO, the same finish request aborts to IDLE.

Source files
------------

// File: rtl/control_partida_if.sv
// Menu-to-round-controller link.
// The menu (master) drives its state code, level code and load strobe.
// The game field also drives the event pulses (tick, arrival, collision) through it.
// The round controller (slave) only reads these signals.
//   estado_in : menu state code (001..100 level select, 111 in game, 000 idle/finish)
//   nvl_in    : menu level code, valid while cn_in=1
//   cn_in     : one-cycle load strobe
//   tick      : one-cycle timebase pulse
//   llegada   : one-cycle pulse, frog reached the goal row
//   choque    : one-cycle pulse, frog collided or drowned
interface control_partida_if #(
  parameter int DATAWIDTH_ESTADO = 3,
  parameter int DATAWIDTH_NIVEL  = 2
);
  logic [DATAWIDTH_ESTADO-1:0] estado_in;
  logic [DATAWIDTH_NIVEL-1:0]  nvl_in;
  logic                        cn_in;
  logic                        tick;
  logic                        llegada;
  logic                        choque;

  modport master (
    output estado_in, nvl_in, cn_in, tick, llegada, choque
  );

  modport slave (
    input estado_in, nvl_in, cn_in, tick, llegada, choque
  );
endinterface

// File: rtl/control_partida.sv
// Game-round controller, responder side of the main-menu link.
// It arms on a level-select load strobe and starts play when the menu enters the
// in-game code. It then tracks lives, a per-life countdown and goal arrivals, and it
// raises the won/lost flags for the menu.
//   CP_CLOCK_50 : clock, rising edge
//   CP_RESET    : asynchronous active-low reset
//   menu        : menu/event inputs (slave modport)
//   CP_GANO     : round won (held until finish request/reset)
//   CP_PERDIO   : round lost (held until finish request/reset)
//   CP_RESPAWN  : one-cycle pulse, reposition frog
//   CP_ACTIVO   : high while playing or respawning
//   CP_NVL_OUT  : latched level
//   CP_VIDAS    : remaining lives
//   CP_TIEMPO   : remaining ticks for the current life
//   CP_LLEGADAS : arrivals this round
module control_partida #(
  parameter int DATAWIDTH_ESTADO = 3,
  parameter int DATAWIDTH_NIVEL  = 2,
  parameter int DATAWIDTH_TIEMPO = 8,
  parameter int VIDAS_INI        = 3,
  parameter int LLEGADAS_META    = 3,
  parameter int TIEMPO_BASE      = 60,
  parameter int TIEMPO_PASO      = 10
) (
  input  logic                        CP_CLOCK_50,
  input  logic                        CP_RESET,
  control_partida_if.slave            menu,
  output logic                        CP_GANO,
  output logic                        CP_PERDIO,
  output logic                        CP_RESPAWN,
  output logic                        CP_ACTIVO,
  output logic [DATAWIDTH_NIVEL-1:0]  CP_NVL_OUT,
  output logic [1:0]                  CP_VIDAS,
  output logic [DATAWIDTH_TIEMPO-1:0] CP_TIEMPO,
  output logic [2:0]                  CP_LLEGADAS
);

  localparam int TW = DATAWIDTH_TIEMPO;
  localparam int NW = DATAWIDTH_NIVEL;
  localparam int EW = DATAWIDTH_ESTADO;

  typedef enum logic [2:0] {
    IDLE,
    ARMADO,
    JUGANDO,
    RESPAWN,
    GANADO,
    PERDIDO
  } state_t;

  state_t          state, state_nx;
  logic [NW-1:0]   nvl_q, nvl_nx;
  logic [1:0]      vidas_q, vidas_nx;
  logic [TW-1:0]   tiempo_q, tiempo_nx;
  logic [2:0]      llegadas_q, llegadas_nx;

  logic            fin_req;
  logic            inicio_req;
  logic            pierde_vida;
  logic [TW-1:0]   recarga;

  function automatic logic [TW-1:0] tiempo_nivel(input logic [NW-1:0] n);
    return TW'(TIEMPO_BASE - TIEMPO_PASO * int'(n));
  endfunction

  assign fin_req    = menu.cn_in && (menu.estado_in == '0);
  assign inicio_req = menu.cn_in && (menu.estado_in != '0) && (menu.estado_in <= EW'(4));
  assign recarga    = tiempo_nivel(nvl_q);
  // A tick on the last remaining unit counts as a collision, so the timer never wraps.
  assign pierde_vida = menu.choque || (menu.tick && (tiempo_q == TW'(1)));

  always_ff @(posedge CP_CLOCK_50 or negedge CP_RESET) begin
    if (!CP_RESET) begin
      state      <= IDLE;
      nvl_q      <= '0;
      vidas_q    <= '0;
      tiempo_q   <= '0;
      llegadas_q <= '0;
    end else begin
      state      <= state_nx;
      nvl_q      <= nvl_nx;
      vidas_q    <= vidas_nx;
      tiempo_q   <= tiempo_nx;
      llegadas_q <= llegadas_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    nvl_nx      = nvl_q;
    vidas_nx    = vidas_q;
    tiempo_nx   = tiempo_q;
    llegadas_nx = llegadas_q;

    if (fin_req) begin
      state_nx    = IDLE;
      nvl_nx      = '0;
      vidas_nx    = '0;
      tiempo_nx   = '0;
      llegadas_nx = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (inicio_req) begin
            state_nx    = ARMADO;
            nvl_nx      = menu.nvl_in;
            vidas_nx    = 2'(VIDAS_INI);
            llegadas_nx = '0;
            tiempo_nx   = tiempo_nivel(menu.nvl_in);
          end
        end
        ARMADO: begin
          if (menu.estado_in == '1) state_nx = JUGANDO;
        end
        JUGANDO: begin
          if (pierde_vida) begin
            if (vidas_q > 2'd1) begin
              vidas_nx  = vidas_q - 2'd1;
              tiempo_nx = recarga;
              state_nx  = RESPAWN;
            end else begin
              vidas_nx = '0;
              state_nx = PERDIDO;
            end
          end else if (menu.llegada) begin
            llegadas_nx = llegadas_q + 3'd1;
            if (llegadas_q + 3'd1 == 3'(LLEGADAS_META)) begin
              state_nx = GANADO;
            end else begin
              tiempo_nx = recarga;
              state_nx  = RESPAWN;
            end
          end else if (menu.tick) begin
            tiempo_nx = tiempo_q - TW'(1);
          end
        end
        RESPAWN: state_nx = JUGANDO;
        GANADO:  state_nx = GANADO;
        PERDIDO: state_nx = PERDIDO;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign CP_GANO     = (state == GANADO);
  assign CP_PERDIO   = (state == PERDIDO);
  assign CP_RESPAWN  = (state == RESPAWN);
  assign CP_ACTIVO   = (state == JUGANDO) || (state == RESPAWN);
  assign CP_NVL_OUT  = nvl_q;
  assign CP_VIDAS    = vidas_q;
  assign CP_TIEMPO   = tiempo_q;
  assign CP_LLEGADAS = llegadas_q;

endmodule

// File: tb/tb_control_partida.sv
module tb_control_partida;

  localparam int VIDAS_INI     = 3;
  localparam int LLEGADAS_META = 3;
  localparam int TIEMPO_BASE   = 60;
  localparam int TIEMPO_PASO   = 10;

  localparam int P_IDLE = 0, P_ARMED = 1, P_PLAY = 2, P_RESP = 3, P_WON = 4, P_LOST = 5;

  typedef struct {
    int          cyc;
    logic [18:0] vec;
  } exp_t;

  logic clk;
  logic rst_n;
  logic gano, perdio, respawn, activo;
  logic [1:0] nvl_out, vidas;
  logic [7:0] tiempo;
  logic [2:0] llegadas;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  exp_t exp_q[$];

  int m_phase, m_nvl, m_vidas, m_tiempo, m_lleg;

  control_partida_if #(.DATAWIDTH_ESTADO(3), .DATAWIDTH_NIVEL(2)) bus ();

  control_partida #(
    .DATAWIDTH_ESTADO(3), .DATAWIDTH_NIVEL(2), .DATAWIDTH_TIEMPO(8),
    .VIDAS_INI(VIDAS_INI), .LLEGADAS_META(LLEGADAS_META),
    .TIEMPO_BASE(TIEMPO_BASE), .TIEMPO_PASO(TIEMPO_PASO)
  ) dut (
    .CP_CLOCK_50(clk), .CP_RESET(rst_n), .menu(bus),
    .CP_GANO(gano), .CP_PERDIO(perdio), .CP_RESPAWN(respawn), .CP_ACTIVO(activo),
    .CP_NVL_OUT(nvl_out), .CP_VIDAS(vidas), .CP_TIEMPO(tiempo), .CP_LLEGADAS(llegadas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  function automatic logic [18:0] dut_vec();
    return {gano, perdio, respawn, activo, nvl_out, vidas, tiempo, llegadas};
  endfunction

  function automatic logic [18:0] model_vec();
    return {m_phase == P_WON, m_phase == P_LOST, m_phase == P_RESP,
            (m_phase == P_PLAY) || (m_phase == P_RESP),
            2'(m_nvl), 2'(m_vidas), 8'(m_tiempo), 3'(m_lleg)};
  endfunction

  task automatic model_clear();
    m_phase = P_IDLE; m_nvl = 0; m_vidas = 0; m_tiempo = 0; m_lleg = 0;
  endtask

  // Round rules: one event per cycle, collision/timeout beats arrival beats tick.
  task automatic model_apply(input int e, input int n, input bit c, t, l, ch);
    bool_block: begin
      bit lose;
      int full_time;
      full_time = TIEMPO_BASE - TIEMPO_PASO * m_nvl;
      lose = ch || (t && m_tiempo == 1);
      if (c && e == 0) begin
        model_clear();
      end else if (m_phase == P_IDLE) begin
        if (c && e >= 1 && e <= 4) begin
          m_phase = P_ARMED; m_nvl = n; m_vidas = VIDAS_INI; m_lleg = 0;
          m_tiempo = TIEMPO_BASE - TIEMPO_PASO * n;
        end
      end else if (m_phase == P_ARMED) begin
        if (e == 7) m_phase = P_PLAY;
      end else if (m_phase == P_RESP) begin
        m_phase = P_PLAY;
      end else if (m_phase == P_PLAY) begin
        if (lose) begin
          m_vidas = m_vidas - 1;
          if (m_vidas == 0) m_phase = P_LOST;
          else begin m_tiempo = full_time; m_phase = P_RESP; end
        end else if (l) begin
          m_lleg = m_lleg + 1;
          if (m_lleg == LLEGADAS_META) m_phase = P_WON;
          else begin m_tiempo = full_time; m_phase = P_RESP; end
        end else if (t) begin
          m_tiempo = m_tiempo - 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drives one cycle of inputs and queues the outputs expected after the next edge.
  task automatic step(input int e, input int n, input bit c, t, l, ch);
    exp_t x;
    @(posedge clk);
    #1;
    bus.estado_in = 3'(e); bus.nvl_in = 2'(n); bus.cn_in = c;
    bus.tick = t; bus.llegada = l; bus.choque = ch;
    model_apply(e, n, c, t, l, ch);
    x.cyc = cyc + 1;
    x.vec = model_vec();
    exp_q.push_back(x);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(7, 0, 0, 0, 0, 0);
  endtask

  task automatic start_round(input int lvl);
    step(0, 0, 1, 0, 0, 0);
    step(lvl + 1, lvl, 1, 0, 0, 0);
    step(7, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare every queued expectation in the cycle it targets.
  initial forever begin
    @(posedge clk);
    #3;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t x;
      x = exp_q.pop_front();
      chk("outputs{gano,perdio,resp,act,nvl,vidas,tiempo,lleg}", 32'(dut_vec()), 32'(x.vec));
      chk("gano_and_perdio", 32'(gano & perdio), 32'd0);
    end
  end

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.estado_in = '0; bus.nvl_in = '0; bus.cn_in = 1'b0;
    bus.tick = 1'b0; bus.llegada = 1'b0; bus.choque = 1'b0;
    model_clear();
    #2;
    chk("reset_outputs", 32'(dut_vec()), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Level 2 round won by three arrivals.
    start_round(2);
    for (int i = 0; i < 3; i++) begin step(7, 0, 0, 0, 1, 0); idle(2); end
    #1;
    chk("win_gano", 32'(gano), 32'd1);
    chk("win_llegadas", 32'(llegadas), 32'd3);

    // Finish request out of GANADO.
    step(0, 0, 1, 0, 0, 0); idle(1);
    #1;
    chk("finish_clears", 32'(dut_vec()), 32'd0);

    // Level 0 round lost by three collisions.
    start_round(0);
    for (int i = 0; i < 3; i++) begin step(7, 0, 0, 0, 0, 1); idle(2); end
    #1;
    chk("lose_perdio", 32'({perdio, gano}), 32'b10);
    chk("lose_vidas", 32'(vidas), 32'd0);

    // Level 3: 30 ticks, the last one times the life out.
    start_round(3);
    for (int i = 0; i < 30; i++) step(7, 0, 0, 1, 0, 0);
    idle(1);
    #1;
    chk("timeout_vidas", 32'(vidas), 32'd2);
    chk("timeout_tiempo", 32'(tiempo), 32'd30);
    chk("timeout_respawn", 32'(respawn), 32'd1);

    // Simultaneous events at level 1: only the collision counts.
    start_round(1);
    step(7, 0, 0, 1, 1, 1); idle(1);
    #1;
    chk("prio_vidas_lleg_tiempo", 32'({vidas, llegadas, tiempo}), 32'({2'd2, 3'd0, 8'd50}));

    // Abort while playing.
    idle(2);
    step(0, 0, 1, 0, 0, 0); idle(1);
    #1;
    chk("abort_playing", 32'(dut_vec()), 32'd0);
    drain();

    // Random menu/event traffic.
    for (int i = 0; i < 3000; i++) begin
      int e;
      e = ($urandom_range(0, 9) < 6) ? 7 : int'($urandom_range(0, 7));
      step(e, int'($urandom_range(0, 3)), $urandom_range(0, 19) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 19) == 0);
      if (i == 1500) begin
        drain();
        @(posedge clk); #2 rst_n = 1'b0;
        #1 chk("async_reset_midcycle", 32'(dut_vec()), 32'd0);
        model_clear();
        @(posedge clk); #1 rst_n = 1'b1;
      end
    end
    step(7, 0, 0, 0, 0, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
